// File: rtl/ysyx_22040386_muldiv_seq.sv
// Multi-cycle RV64M multiply/divide sequencer with a valid/ready handshake and flush.
// Multiplies take two cycles. Divides use a restoring shift-subtract loop with one result bit per cycle.
module ysyx_22040386_muldiv_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  funct3,
  input  logic        word_op,
  input  logic [63:0] src1,
  input  logic [63:0] src2,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

  state_e              state_q;
  logic [6:0]          cnt_q;
  logic [63:0]         result_q;
  logic                out_valid_q;
  logic                busy_q;

  logic [1:0]          fn_q;
  logic                word_q;
  logic signed [64:0]  mul_a_q, mul_b_q;
  logic [63:0]         rem_q, quot_q, dvsr_q;
  logic                qneg_q, rneg_q;

  function automatic logic [63:0] sext32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  function automatic logic [63:0] wfix(input logic w, input logic [63:0] x);
    return w ? sext32(x[31:0]) : x;
  endfunction

  logic                accept;
  logic                is_signed, dvd_neg, dvs_neg, div_zero, div_ovf;
  logic [63:0]         dvd_ext, dvs_ext, dvd_mag, dvs_mag, special_res;
  logic signed [64:0]  mul_a_d, mul_b_d;

  assign in_ready = (state_q == S_IDLE) & ~flush;
  assign accept   = in_valid & in_ready;

  always_comb begin
    is_signed = ~funct3[0];
    dvd_ext   = src1;
    dvs_ext   = src2;
    if (word_op) begin
      dvd_ext = is_signed ? sext32(src1[31:0]) : {32'd0, src1[31:0]};
      dvs_ext = is_signed ? sext32(src2[31:0]) : {32'd0, src2[31:0]};
    end
    dvd_neg  = is_signed & dvd_ext[63];
    dvs_neg  = is_signed & dvs_ext[63];
    dvd_mag  = dvd_neg ? -dvd_ext : dvd_ext;
    dvs_mag  = dvs_neg ? -dvs_ext : dvs_ext;
    div_zero = word_op ? (src2[31:0] == 32'd0) : (src2 == 64'd0);
    div_ovf  = is_signed & (word_op ?
                 (src1[31:0] == 32'h8000_0000 && src2[31:0] == 32'hFFFF_FFFF) :
                 (src1 == 64'h8000_0000_0000_0000 && src2 == 64'hFFFF_FFFF_FFFF_FFFF));
    if (div_zero)
      special_res = wfix(word_op, funct3[1] ? dvd_ext : 64'hFFFF_FFFF_FFFF_FFFF);
    else
      special_res = wfix(word_op, funct3[1] ? 64'd0 : dvd_ext);
    // mulh: s*s, mulhsu: s*u, mulhu: u*u; mul/mulw only use low bits
    mul_a_d = {(funct3[1:0] != 2'b11) & src1[63], src1};
    mul_b_d = {(funct3[1:0] == 2'b01) & src2[63], src2};
  end

  logic signed [127:0] mul_a_x, mul_b_x, prod;
  logic [63:0]         mul_res;

  assign mul_a_x = {{63{mul_a_q[64]}}, mul_a_q};
  assign mul_b_x = {{63{mul_b_q[64]}}, mul_b_q};
  assign prod    = mul_a_x * mul_b_x;

  always_comb begin
    mul_res = prod[127:64];
    if (word_q)
      mul_res = sext32(prod[31:0]);
    else if (fn_q == 2'b00)
      mul_res = prod[63:0];
  end

  // A borrow is only possible when the bit shifted out of rem is zero
  logic [64:0] trial;
  logic        borrow;
  assign trial  = {rem_q, quot_q[63]} - {1'b0, dvsr_q};
  assign borrow = trial[64] & ~rem_q[63];

  logic [63:0] q_fix, r_fix, fix_res;
  always_comb begin
    q_fix   = qneg_q ? -quot_q : quot_q;
    r_fix   = rneg_q ? -rem_q : rem_q;
    fix_res = wfix(word_q, fn_q[1] ? r_fix : q_fix);
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      fn_q    <= funct3[1:0];
      word_q  <= word_op;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      quot_q  <= word_op ? {dvd_mag[31:0], 32'd0} : dvd_mag;
      rem_q   <= 64'd0;
      dvsr_q  <= dvs_mag;
      qneg_q  <= dvd_neg ^ dvs_neg;
      rneg_q  <= dvd_neg;
    end else if (state_q == S_DIV) begin
      quot_q <= {quot_q[62:0], ~borrow};
      rem_q  <= borrow ? {rem_q[62:0], quot_q[63]} : trial[63:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 7'd0;
      result_q    <= 64'd0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (flush) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            busy_q <= 1'b1;
            if (!funct3[2]) begin
              state_q <= S_MUL;
            end else if (div_zero | div_ovf) begin
              state_q     <= S_DONE;
              result_q    <= special_res;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= S_DIV;
              cnt_q   <= word_op ? 7'd31 : 7'd63;
            end
          end
        end
        S_MUL: begin
          state_q     <= S_DONE;
          result_q    <= mul_res;
          out_valid_q <= 1'b1;
        end
        S_DIV: begin
          if (cnt_q == 7'd0) state_q <= S_FIX;
          else               cnt_q   <= cnt_q - 7'd1;
        end
        S_FIX: begin
          state_q     <= S_DONE;
          result_q    <= fix_res;
          out_valid_q <= 1'b1;
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = result_q;

endmodule

// File: tb/tb_ysyx_22040386_muldiv_seq.sv
// Self-checking bench for the RV64M multiply/divide sequencer.
module tb_ysyx_22040386_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  funct3 = 3'd0;
  logic        word_op = 1'b0;
  logic [63:0] src1 = 64'd0;
  logic [63:0] src2 = 64'd0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] result;
  logic        busy;

  int checks = 0;
  int failures = 0;

  ysyx_22040386_muldiv_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .word_op(word_op), .src1(src1), .src2(src2),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference: architectural result of an RV64M operation
  function automatic logic [63:0] ref_res(input logic [2:0] f, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    logic [63:0]  x, y, q, r, sel;
    logic         sgn;
    if (!f[2]) begin
      case (f[1:0])
        2'b01:   p = {{64{a[63]}}, a} * {{64{b[63]}}, b};
        2'b10:   p = {{64{a[63]}}, a} * {64'd0, b};
        default: p = {64'd0, a} * {64'd0, b};
      endcase
      if (w) return sx32(p[31:0]);
      return (f[1:0] == 2'b00) ? p[63:0] : p[127:64];
    end
    sgn = !f[0];
    x = a;
    y = b;
    if (w) begin
      x = sgn ? sx32(a[31:0]) : {32'd0, a[31:0]};
      y = sgn ? sx32(b[31:0]) : {32'd0, b[31:0]};
    end
    if (y == 64'd0) begin
      q = '1; r = x;
    end else if (sgn && y == '1 &&
                 x == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) begin
      q = x; r = 64'd0;
    end else if (sgn) begin
      q = $signed(x) / $signed(y);
      r = $signed(x) % $signed(y);
    end else begin
      q = x / y;
      r = x % y;
    end
    sel = f[1] ? r : q;
    return w ? sx32(sel[31:0]) : sel;
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    logic zero, ovf;
    if (!f[2]) return 2;
    zero = w ? (b[31:0] == 32'd0) : (b == 64'd0);
    ovf  = !f[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                       : (a == 64'h8000_0000_0000_0000 && b == '1));
    if (zero || ovf) return 1;
    return w ? 34 : 66;
  endfunction

  // Transaction-level model: pending result appears after its latency, held until taken
  logic        m_valid = 1'b0;
  logic        m_busy = 1'b0;
  logic [63:0] m_res = 64'd0;
  logic [63:0] m_pend = 64'd0;
  int          m_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_busy <= 1'b0; m_cnt <= 0; m_res <= 64'd0;
    end else if (flush) begin
      m_valid <= 1'b0; m_busy <= 1'b0; m_cnt <= 0;
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid <= 1'b0; m_busy <= 1'b0;
      end
    end else if (m_busy) begin
      if (m_cnt == 1) begin
        m_valid <= 1'b1; m_res <= m_pend;
      end
      m_cnt <= m_cnt - 1;
    end else if (in_valid) begin
      m_busy <= 1'b1;
      m_pend <= ref_res(funct3, word_op, src1, src2);
      m_cnt  <= ref_lat(funct3, word_op, src1, src2) - 1;
      if (ref_lat(funct3, word_op, src1, src2) == 1) begin
        m_valid <= 1'b1;
        m_res   <= ref_res(funct3, word_op, src1, src2);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_out_valid", 64'(out_valid), 64'(m_valid));
      chk("cyc_busy", 64'(busy), 64'(m_busy));
      chk("cyc_in_ready", 64'(in_ready), 64'(!m_busy && !flush));
      chk("cyc_result", result, m_res);
    end
  end

  task automatic run_op(input logic [2:0] f, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp_v,
                        input int exp_lat, input int hold);
    int n;
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    chk("ready_wait", 64'(in_ready), 64'd1);
    funct3 = f; word_op = w; src1 = a; src2 = b;
    out_ready = (hold == 0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    funct3 = ~f; word_op = ~w; src1 = ~a; src2 = ~b;
    n = 1;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", 64'(n), 64'(exp_lat));
    chk("result", result, exp_v);
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clk); #1;
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_result", result, exp_v);
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("released", 64'(out_valid), 64'd0);
  endtask

  initial begin
    int seen;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66, 0);
    run_op(3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66, 0);
    run_op(3'b101, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    run_op(3'b111, 1'b0, 64'd5, 64'd0, 64'd5, 1, 0);
    run_op(3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, 0);
    run_op(3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1, 0);
    run_op(3'b100, 1'b1, 64'h0000_0000_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1, 0);
    run_op(3'b101, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 34, 0);
    run_op(3'b110, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34, 0);
    run_op(3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 66, 0);
    run_op(3'b111, 1'b0, 64'd100, 64'd7, 64'd2, 66, 0);
    run_op(3'b011, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 2, 0);
    run_op(3'b001, 1'b0, '1, '1, 64'd0, 2, 0);
    run_op(3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 2, 0);
    run_op(3'b000, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 2, 0);
    run_op(3'b010, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0);
    run_op(3'b000, 1'b0, 64'd6, 64'd7, 64'd42, 2, 5);

    // Flush during the 10th divide iteration
    funct3 = 3'b100; word_op = 1'b0; src1 = 64'd100; src2 = 64'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_result_kept", result, 64'd42);
    seen = 0;
    repeat (70) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("flush_no_result", 64'(seen), 64'd0);

    // Request in the same cycle as flush is ignored
    funct3 = 3'b000; src1 = 64'd3; src2 = 64'd3; in_valid = 1'b1; flush = 1'b1;
    #1;
    chk("flush_blocks_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_no_accept", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of a divide
    funct3 = 3'b100; word_op = 1'b0; src1 = 64'd1000; src2 = 64'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1; rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_result", result, 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(3'b100, 1'b1, 64'd21, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFD, 34, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    failures++;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
